// File: rtl/debug_request_responder.sv
// CPU-side responder for the debug request/acknowledge handshake: decodes the latched
// command, runs it on the CPU bus or core run-control, then pulses ACKX.
module debug_request_responder #(
  parameter int unsigned AW            = 16,
  parameter int unsigned DW            = 16,
  parameter int unsigned TIMEOUT       = 255,
  parameter int unsigned ACK_CYCLES    = 2,
  parameter bit          HALT_ON_RESET = 1'b0
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          REQX,
  input  logic [2:0]    OPCODE,
  input  logic [AW-1:0] ADDR,
  input  logic [DW-1:0] WDATA,
  output logic          ACKX,
  output logic [DW-1:0] RDATA,
  output logic          ERR,
  output logic          BUSY,
  output logic          BUS_REQ,
  input  logic          BUS_GNT,
  output logic [AW-1:0] BUS_ADDR,
  output logic [DW-1:0] BUS_DOUT,
  output logic          BUS_RD,
  output logic          BUS_WR,
  input  logic [DW-1:0] BUS_DIN,
  input  logic          BUS_RDY,
  output logic          HALTED,
  output logic          STEP
);

  localparam logic [2:0] OpRd     = 3'd1;
  localparam logic [2:0] OpWr     = 3'd2;
  localparam logic [2:0] OpHalt   = 3'd3;
  localparam logic [2:0] OpResume = 3'd4;
  localparam logic [2:0] OpStep   = 3'd5;
  localparam logic [2:0] OpRdInc  = 3'd6;
  localparam logic [2:0] OpWrInc  = 3'd7;

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CW = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
  localparam logic [TW-1:0] TLast = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ALast = CW'(ACK_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StGrant, StAccess, StAck, StRelease} state_e;

  state_e          state_q;
  logic [2:0]      op_q;
  logic [DW-1:0]   wdata_q;
  logic [AW-1:0]   ptr_q;
  logic [TW-1:0]   tcnt_q;
  logic [CW-1:0]   acnt_q;
  logic            ackx_q, err_q, busy_q, bus_req_q, bus_rd_q, bus_wr_q, halted_q, step_q;
  logic [DW-1:0]   rdata_q, bus_dout_q;
  logic [AW-1:0]   bus_addr_q;

  logic is_rd, is_inc, done, tmo;

  always_comb begin
    is_rd  = (op_q == OpRd) || (op_q == OpRdInc);
    is_inc = (op_q == OpRdInc) || (op_q == OpWrInc);
    done   = (state_q == StAccess) && BUS_RDY;
    // Completion in ACCESS wins over a timeout landing on the same cycle.
    tmo    = !done && (tcnt_q == TLast);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= StIdle;
      op_q       <= 3'd0;
      wdata_q    <= '0;
      ptr_q      <= '0;
      tcnt_q     <= '0;
      acnt_q     <= '0;
      ackx_q     <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      bus_req_q  <= 1'b0;
      bus_addr_q <= '0;
      bus_dout_q <= '0;
      bus_rd_q   <= 1'b0;
      bus_wr_q   <= 1'b0;
      halted_q   <= HALT_ON_RESET;
      step_q     <= 1'b0;
    end else begin
      step_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (REQX) begin
            op_q    <= OPCODE;
            wdata_q <= WDATA;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            case (OPCODE)
              OpRd, OpWr, OpRdInc, OpWrInc: begin
                if ((OPCODE == OpRd) || (OPCODE == OpWr)) ptr_q <= ADDR;
                bus_req_q <= 1'b1;
                tcnt_q    <= '0;
                state_q   <= StGrant;
              end
              default: begin
                if (OPCODE == OpHalt) halted_q <= 1'b1;
                if (OPCODE == OpResume) halted_q <= 1'b0;
                if (OPCODE == OpStep) begin
                  if (halted_q) step_q <= 1'b1;
                  else          err_q  <= 1'b1;
                end
                ackx_q  <= 1'b1;
                acnt_q  <= '0;
                state_q <= StAck;
              end
            endcase
          end
        end
        StGrant, StAccess: begin
          if (done || tmo) begin
            if (done && is_rd) rdata_q <= BUS_DIN;
            if (done && is_inc) ptr_q <= ptr_q + AW'(1);
            if (tmo) err_q <= 1'b1;
            bus_req_q  <= 1'b0;
            bus_rd_q   <= 1'b0;
            bus_wr_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_dout_q <= '0;
            ackx_q     <= 1'b1;
            acnt_q     <= '0;
            state_q    <= StAck;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
            if ((state_q == StGrant) && BUS_GNT) begin
              bus_addr_q <= ptr_q;
              bus_rd_q   <= is_rd;
              bus_wr_q   <= !is_rd;
              if (!is_rd) bus_dout_q <= wdata_q;
              state_q    <= StAccess;
            end
          end
        end
        StAck: begin
          if (acnt_q == ALast) begin
            ackx_q  <= 1'b0;
            state_q <= StRelease;
          end else begin
            acnt_q <= acnt_q + CW'(1);
          end
        end
        StRelease: begin
          // Only a dropped REQX re-arms IDLE, so a stuck request cannot replay a command.
          if (!REQX) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ACKX     = ackx_q;
  assign RDATA    = rdata_q;
  assign ERR      = err_q;
  assign BUSY     = busy_q;
  assign BUS_REQ  = bus_req_q;
  assign BUS_ADDR = bus_addr_q;
  assign BUS_DOUT = bus_dout_q;
  assign BUS_RD   = bus_rd_q;
  assign BUS_WR   = bus_wr_q;
  assign HALTED   = halted_q;
  assign STEP     = step_q;

endmodule

// File: tb/tb_debug_request_responder.sv
// Randomised bench for debug_request_responder: a bus slave with programmable grant/ready
// delays plus a transaction-level reference model of pointer, memory and run-control.
module tb_debug_request_responder;

  localparam int unsigned AW            = 16;
  localparam int unsigned DW            = 16;
  localparam int unsigned TIMEOUT       = 255;
  localparam int unsigned ACK_CYCLES    = 2;
  localparam bit          HALT_ON_RESET = 1'b0;

  localparam logic [2:0] OpNop    = 3'd0;
  localparam logic [2:0] OpRd     = 3'd1;
  localparam logic [2:0] OpWr     = 3'd2;
  localparam logic [2:0] OpHalt   = 3'd3;
  localparam logic [2:0] OpResume = 3'd4;
  localparam logic [2:0] OpStep   = 3'd5;
  localparam logic [2:0] OpRdInc  = 3'd6;
  localparam logic [2:0] OpWrInc  = 3'd7;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          REQX = 1'b0;
  logic [2:0]    OPCODE = 3'd0;
  logic [AW-1:0] ADDR = '0;
  logic [DW-1:0] WDATA = '0;
  logic          ACKX, ERR, BUSY, BUS_REQ, BUS_RD, BUS_WR, HALTED, STEP;
  logic [DW-1:0] RDATA, BUS_DOUT;
  logic [AW-1:0] BUS_ADDR;
  logic          BUS_GNT = 1'b0;
  logic          BUS_RDY = 1'b0;
  logic [DW-1:0] BUS_DIN = '0;

  always #5 CLK = ~CLK;

  debug_request_responder #(
    .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .ACK_CYCLES(ACK_CYCLES), .HALT_ON_RESET(HALT_ON_RESET)
  ) dut (
    .CLK(CLK), .RESET(RESET), .REQX(REQX), .OPCODE(OPCODE), .ADDR(ADDR), .WDATA(WDATA),
    .ACKX(ACKX), .RDATA(RDATA), .ERR(ERR), .BUSY(BUSY), .BUS_REQ(BUS_REQ), .BUS_GNT(BUS_GNT),
    .BUS_ADDR(BUS_ADDR), .BUS_DOUT(BUS_DOUT), .BUS_RD(BUS_RD), .BUS_WR(BUS_WR),
    .BUS_DIN(BUS_DIN), .BUS_RDY(BUS_RDY), .HALTED(HALTED), .STEP(STEP)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] fill(input logic [15:0] a);
    return a ^ 16'h5a5a;
  endfunction

  // Slave-side memory (written by the DUT) and model memory (written by the model).
  logic [15:0] mem [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];

  function automatic logic [15:0] rd_mem(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : fill(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction

  // Bus slave and monitors; all sampling on the falling edge.
  int gnt_delay = 0;
  int rdy_delay = 0;
  int gcnt = 0, rcnt = 0, hold_err = 0, step_cnt = 0, ack_cnt = 0, req_cnt = 0;
  bit in_acc = 1'b0;
  logic [15:0] cur_addr, cur_data;
  logic        cur_wr;
  logic [15:0] acc_addr_q[$];
  logic [15:0] acc_data_q[$];
  logic        acc_wr_q[$];

  always @(negedge CLK) begin
    if (STEP) step_cnt++;
    if (ACKX) ack_cnt++;
    if (BUS_REQ) req_cnt++;
    BUS_RDY = 1'b0;
    BUS_DIN = 16'($urandom);
    if (!BUS_REQ) begin
      gcnt = 0;
      BUS_GNT = 1'b0;
    end else if (gnt_delay >= 0 && gcnt >= gnt_delay) begin
      BUS_GNT = 1'b1;
    end else begin
      gcnt++;
    end
    if (BUS_RD || BUS_WR) begin
      if (!in_acc) begin
        in_acc = 1'b1;
        rcnt = 0;
        cur_addr = BUS_ADDR;
        cur_data = BUS_DOUT;
        cur_wr = BUS_WR;
        acc_addr_q.push_back(BUS_ADDR);
        acc_data_q.push_back(BUS_DOUT);
        acc_wr_q.push_back(BUS_WR);
      end else if (BUS_ADDR !== cur_addr || BUS_WR !== cur_wr || BUS_RD === BUS_WR ||
                   (cur_wr && BUS_DOUT !== cur_data)) begin
        hold_err++;
      end
      if (rcnt >= rdy_delay) begin
        BUS_RDY = 1'b1;
        if (BUS_WR) mem[BUS_ADDR] = BUS_DOUT;
        else BUS_DIN = rd_mem(BUS_ADDR);
      end else begin
        rcnt++;
      end
    end else begin
      in_acc = 1'b0;
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  // Reference model state
  logic [15:0] m_ptr = 16'h0;
  logic [15:0] m_rdata = 16'h0;
  logic        m_halted = HALT_ON_RESET;

  task automatic run_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] wd,
                         input int g, input int r, input bit hold);
    bit is_bus, is_rd, is_inc, got;
    int exp_lat, exp_acc, exp_req, exp_step, lat, w, s_step, s_req, s_ack, s_acc, s_hold;
    logic exp_err;
    logic [15:0] exp_addr;
    is_bus = op inside {OpRd, OpWr, OpRdInc, OpWrInc};
    is_rd = (op == OpRd) || (op == OpRdInc);
    is_inc = (op == OpRdInc) || (op == OpWrInc);
    exp_err = 1'b0; exp_step = 0; exp_acc = 0; exp_req = 0; exp_addr = 16'h0; exp_lat = 1;
    if (is_bus) begin
      if (op == OpRd || op == OpWr) m_ptr = a;
      if (g < 0) begin
        exp_err = 1'b1;
        exp_lat = TIMEOUT + 1;
        exp_req = TIMEOUT;
      end else begin
        exp_addr = m_ptr;
        exp_acc = 1;
        exp_req = g + r + 2;
        exp_lat = g + r + 3;
        if (is_rd) m_rdata = ref_rd(m_ptr);
        else ref_mem[m_ptr] = wd;
        if (is_inc) m_ptr = m_ptr + 16'd1;
      end
    end else if (op == OpHalt) begin
      m_halted = 1'b1;
    end else if (op == OpResume) begin
      m_halted = 1'b0;
    end else if (op == OpStep) begin
      if (m_halted) exp_step = 1;
      else exp_err = 1'b1;
    end

    s_step = step_cnt; s_req = req_cnt; s_ack = ack_cnt; s_hold = hold_err;
    s_acc = acc_addr_q.size();
    gnt_delay = g;
    rdy_delay = r;
    REQX = 1'b1; OPCODE = op; ADDR = a; WDATA = wd;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < int'(TIMEOUT) + 50 && !got; i++) begin
      tick();
      lat++;
      OPCODE = 3'($urandom); ADDR = 16'($urandom); WDATA = 16'($urandom);
      if (ACKX) got = 1'b1;
    end
    check("ack_seen", got, 1);
    check("latency", lat, exp_lat);
    check("rdata", RDATA, m_rdata);
    check("err", ERR, exp_err);
    w = 0;
    while (ACKX && w < 20) begin
      w++;
      tick();
    end
    check("ack_width", w, ACK_CYCLES);
    if (hold) begin
      repeat (6) tick();
      check("busy_held", BUSY, 1);
    end
    REQX = 1'b0;
    for (int i = 0; i < 10 && BUSY; i++) tick();
    check("busy_clr", BUSY, 0);
    check("halted", HALTED, m_halted);
    check("step_pulses", step_cnt - s_step, exp_step);
    check("ack_total", ack_cnt - s_ack, ACK_CYCLES);
    check("bus_accesses", acc_addr_q.size() - s_acc, exp_acc);
    check("req_cycles", req_cnt - s_req, exp_req);
    check("strobe_hold", hold_err - s_hold, 0);
    if (exp_acc == 1 && acc_addr_q.size() > s_acc) begin
      check("bus_addr", acc_addr_q[s_acc], exp_addr);
      check("bus_kind", acc_wr_q[s_acc], !is_rd);
      if (!is_rd) check("bus_wdata", acc_data_q[s_acc], wd);
    end
  endtask

  initial begin
    bit got;
    int s_ack;
    repeat (3) tick();
    RESET = 1'b0;
    repeat (2) tick();
    check("rst_flags", {ACKX, ERR, BUSY, BUS_REQ, BUS_RD, BUS_WR, STEP}, 0);
    check("rst_halted", HALTED, HALT_ON_RESET);
    check("rst_rdata", RDATA, 0);
    check("rst_bus", {BUS_ADDR, BUS_DOUT}, 0);

    run_cmd(OpWr, 16'h1234, 16'hbeef, 3, 2, 1'b0);
    preload(16'h0100, 16'ha5a5);
    run_cmd(OpRd, 16'h0100, 16'h0000, 0, 0, 1'b0);
    preload(16'hffff, 16'h1111);
    preload(16'h0000, 16'h2222);
    run_cmd(OpRd, 16'hffff, 16'h0000, 0, 0, 1'b0);
    run_cmd(OpRdInc, 16'h7777, 16'h0000, 1, 0, 1'b0);
    run_cmd(OpRdInc, 16'h7777, 16'h0000, 0, 1, 1'b0);
    run_cmd(OpRdInc, 16'h4444, 16'h0000, -1, 0, 1'b0);
    run_cmd(OpRdInc, 16'h4444, 16'h0000, 0, 1, 1'b0);
    run_cmd(OpStep, 16'h0, 16'h0, 0, 0, 1'b0);
    run_cmd(OpHalt, 16'h0, 16'h0, 0, 0, 1'b0);
    run_cmd(OpStep, 16'h0, 16'h0, 0, 0, 1'b0);
    run_cmd(OpResume, 16'h0, 16'h0, 0, 0, 1'b0);
    run_cmd(OpNop, 16'h0, 16'h0, 0, 0, 1'b0);
    run_cmd(OpWrInc, 16'h0, 16'h3c3c, 2, 1, 1'b1);

    // Reset while a read is stalled in ACCESS.
    gnt_delay = 0;
    rdy_delay = 40;
    s_ack = ack_cnt;
    REQX = 1'b1; OPCODE = OpRd; ADDR = 16'h0200; WDATA = 16'h0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = BUS_RD;
    end
    check("rst_reach_access", got, 1);
    #2 RESET = 1'b1;
    #1;
    check("rst_async_flags", {ACKX, ERR, BUSY, BUS_REQ, BUS_RD, BUS_WR, STEP}, 0);
    check("rst_async_bus", {BUS_ADDR, BUS_DOUT, RDATA}, 0);
    check("rst_async_halted", HALTED, HALT_ON_RESET);
    REQX = 1'b0;
    repeat (2) tick();
    RESET = 1'b0;
    repeat (3) tick();
    check("rst_idle", BUSY, 0);
    check("rst_no_ack", ack_cnt - s_ack, 0);
    m_ptr = 16'h0;
    m_rdata = 16'h0;
    m_halted = HALT_ON_RESET;
    run_cmd(OpRdInc, 16'h9999, 16'h0, 0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_cmd(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
